spram_port_arbiter: RTL

SPRAM_PORT_ARBITER -- requirements
Module: spram_port_arbiter

---
 rtl/spram_port_arbiter_if.sv | 25 ++
 rtl/spram_port_arbiter.sv | 71 +++++++
 2 files changed

// File: rtl/spram_port_arbiter_if.sv
// spram_port_arbiter_if: write/read request and read response handshakes of the arbiter
interface spram_port_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 10
);
    logic              wr_valid;
    logic              wr_ready;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic [DW/8-1:0]   wr_mask;
    logic              rd_valid;
    logic              rd_ready;
    logic [AW-1:0]     rd_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DW-1:0]     rsp_data;
    modport master (
        output wr_valid, wr_addr, wr_data, wr_mask, rd_valid, rd_addr, rsp_ready,
        input  wr_ready, rd_ready, rsp_valid, rsp_data
    );
    modport slave (
        input  wr_valid, wr_addr, wr_data, wr_mask, rd_valid, rd_addr, rsp_ready,
        output wr_ready, rd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/spram_port_arbiter.sv
// spram_port_arbiter: round-robin serialisation of write and read streams onto one single-port RAM
module spram_port_arbiter #(
    parameter int DW = 32,
    parameter int AW = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    spram_port_arbiter_if.slave     bus,
    output logic                    ram_ce_o,
    output logic                    ram_we_o,
    output logic [AW-1:0]           ram_addr_o,
    output logic [DW-1:0]           ram_din_o,
    output logic [DW-1:0]           ram_wmask_o,
    input  logic [DW-1:0]           ram_dout_i
);
    logic [1:0]    count_q, count_d, wptr_q, wptr_d, rptr_q, rptr_d;
    logic          inflight_q, rr_q, rr_d;
    logic [DW-1:0] mem_q [3];
    logic [2:0]    credit;
    logic          wr_elig, rd_elig, grant_w, grant_r, push, pop;

    // Credit counts only registered state, so rsp_ready never reaches the readies.
    always_comb begin
        credit  = {1'b0, count_q} + {2'b0, inflight_q};
        wr_elig = bus.wr_valid && !reset;
        rd_elig = bus.rd_valid && !reset && (credit < 3'd3);
        grant_w = wr_elig && (!rd_elig || !rr_q);
        grant_r = rd_elig && !grant_w;
        rr_d    = (wr_elig && rd_elig) ? grant_w : rr_q;
        push    = inflight_q;
        pop     = bus.rsp_valid && bus.rsp_ready;
        count_d = count_q + {1'b0, push} - {1'b0, pop};
        wptr_d  = push ? ((wptr_q == 2'd2) ? 2'd0 : wptr_q + 2'd1) : wptr_q;
        rptr_d  = pop ? ((rptr_q == 2'd2) ? 2'd0 : rptr_q + 2'd1) : rptr_q;
    end

    assign bus.wr_ready  = grant_w;
    assign bus.rd_ready  = grant_r;
    assign bus.rsp_valid = !reset && (count_q != 2'd0);
    assign bus.rsp_data  = mem_q[rptr_q];
    assign ram_ce_o      = grant_w || grant_r;
    assign ram_we_o      = grant_w;
    assign ram_addr_o    = grant_w ? bus.wr_addr : bus.rd_addr;
    assign ram_din_o     = bus.wr_data;

    for (genvar i = 0; i < DW/8; i++) begin : g_mask
        assign ram_wmask_o[8*i +: 8] = {8{grant_w && bus.wr_mask[i]}};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= 2'd0;
            wptr_q     <= 2'd0;
            rptr_q     <= 2'd0;
            inflight_q <= 1'b0;
            rr_q       <= 1'b0;
        end else begin
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            inflight_q <= grant_r;
            rr_q       <= rr_d;
        end
    end

    // A read in flight across reset is dropped here rather than landing in the FIFO.
    always_ff @(posedge clk) begin
        if (push && !reset)
            mem_q[wptr_q] <= ram_dout_i;
    end
endmodule
